// File: rtl/time_counter_pkg.sv
// Shared time-of-day constants and helpers, reused by the splitter and alarm blocks.
// Optional BCD outputs of time_counter are enabled by defining TIME_COUNTER_BCD_EN.
package time_counter_pkg;

  localparam logic [7:0]  SEC_MAX          = 8'd59;
  localparam logic [7:0]  MIN_MAX          = 8'd59;
  localparam logic [7:0]  HOUR_MAX         = 8'd23;
  localparam int unsigned TICK_DIV_DEFAULT = 32'd100_000_000;

  function automatic logic field_valid(input logic [7:0] value, input logic [7:0] max_value);
    return (value <= max_value);
  endfunction

endpackage

// File: rtl/time_counter_bin2bcd8.sv
// Combinational binary (0-99) to packed BCD {tens, ones} converter.
module bin2bcd8 (
  input  logic [7:0] bin,
  output logic [7:0] bcd
);

  logic [3:0] tens_s;
  logic [3:0] ones_s;

  // Split into decimal digits.
  always_comb begin
    tens_s = 4'(bin / 8'd10);
    ones_s = 4'(bin - ({4'd0, tens_s} * 8'd10));
    bcd    = {tens_s, ones_s};
  end

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter: prescaled 1 Hz tick, preset load, hour/day rollover pulses.
// Define TIME_COUNTER_BCD_EN to add registered packed-BCD copies of the time fields.
module time_counter
  import time_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       run,
  input  logic       PE_counter,
  input  logic [7:0] pre_sec,
  input  logic [7:0] pre_min,
  input  logic [7:0] pre_hour,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       tick,
  output logic       hour_pulse,
  output logic       day_pulse,
  output logic       load_err
`ifdef TIME_COUNTER_BCD_EN
  ,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd
`endif
);

  localparam int unsigned    PW         = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 32'd1);

  logic [PW-1:0] presc_d, presc_q;
  logic [7:0]    sec_d, sec_q;
  logic [7:0]    min_d, min_q;
  logic [7:0]    hour_d, hour_q;
  logic          tick_d, tick_q;
  logic          hour_pulse_d, hour_pulse_q;
  logic          day_pulse_d, day_pulse_q;
  logic          load_err_d, load_err_q;

  // Next-state: load beats count; every carry resolves on the tick edge itself.
  always_comb begin
    presc_d      = presc_q;
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    tick_d       = 1'b0;
    hour_pulse_d = 1'b0;
    day_pulse_d  = 1'b0;
    load_err_d   = 1'b0;
    if (PE_counter) begin
      sec_d      = field_valid(pre_sec,  SEC_MAX)  ? pre_sec  : 8'd0;
      min_d      = field_valid(pre_min,  MIN_MAX)  ? pre_min  : 8'd0;
      hour_d     = field_valid(pre_hour, HOUR_MAX) ? pre_hour : 8'd0;
      load_err_d = !field_valid(pre_sec, SEC_MAX) || !field_valid(pre_min, MIN_MAX)
                   || !field_valid(pre_hour, HOUR_MAX);
      presc_d    = {PW{1'b0}};
    end else if (run) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = {PW{1'b0}};
        tick_d  = 1'b1;
        if (sec_q >= SEC_MAX) begin
          sec_d = 8'd0;
          if (min_q >= MIN_MAX) begin
            min_d        = 8'd0;
            hour_pulse_d = 1'b1;
            if (hour_q >= HOUR_MAX) begin
              hour_d      = 8'd0;
              day_pulse_d = 1'b1;
            end else begin
              hour_d = hour_q + 8'd1;
            end
          end else begin
            min_d = min_q + 8'd1;
          end
        end else begin
          sec_d = sec_q + 8'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (CR) begin
      presc_q      <= {PW{1'b0}};
      sec_q        <= 8'd0;
      min_q        <= 8'd0;
      hour_q       <= 8'd0;
      tick_q       <= 1'b0;
      hour_pulse_q <= 1'b0;
      day_pulse_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      tick_q       <= tick_d;
      hour_pulse_q <= hour_pulse_d;
      day_pulse_q  <= day_pulse_d;
      load_err_q   <= load_err_d;
    end
  end

  assign sec        = sec_q;
  assign min        = min_q;
  assign hour       = hour_q;
  assign tick       = tick_q;
  assign hour_pulse = hour_pulse_q;
  assign day_pulse  = day_pulse_q;
  assign load_err   = load_err_q;

`ifdef TIME_COUNTER_BCD_EN
  logic [7:0] sec_bcd_d, sec_bcd_q;
  logic [7:0] min_bcd_d, min_bcd_q;
  logic [7:0] hour_bcd_d, hour_bcd_q;

  // Converted from next-state values so BCD lines up with the binary outputs.
  bin2bcd8 u_sec_bcd  (.bin(sec_d),  .bcd(sec_bcd_d));
  bin2bcd8 u_min_bcd  (.bin(min_d),  .bcd(min_bcd_d));
  bin2bcd8 u_hour_bcd (.bin(hour_d), .bcd(hour_bcd_d));

  // BCD output registers.
  always_ff @(posedge clk) begin
    if (CR) begin
      sec_bcd_q  <= 8'h00;
      min_bcd_q  <= 8'h00;
      hour_bcd_q <= 8'h00;
    end else begin
      sec_bcd_q  <= sec_bcd_d;
      min_bcd_q  <= min_bcd_d;
      hour_bcd_q <= hour_bcd_d;
    end
  end

  assign sec_bcd  = sec_bcd_q;
  assign min_bcd  = min_bcd_q;
  assign hour_bcd = hour_bcd_q;
`endif

endmodule
